// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the second-generation UART
//               receiver. Holds the receive FSM state encoding, the lower
//               oversampling bound, and the parity helper used by the
//               frame checker.
// Contents    : rx_state_t      - receive FSM state (3-bit encoding)
//               MIN_PRESCALE    - smallest supported oversampling ratio
//               MAX_DATA_WIDTH  - widest supported data word
//               parity_of()     - expected parity bit for a data word
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Smallest oversampling ratio the sampler is designed for. Below this the
  // three-sample window around mid-bit no longer fits inside one bit period.
  localparam int MIN_PRESCALE = 8;

  // Widest data word any receiver instance may be configured with.
  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Expected parity bit: typ = 0 gives even parity, typ = 1 gives odd.
  // Narrower words are zero-extended by the caller, which leaves the XOR
  // reduction unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_WIDTH-1:0] data,
                                     input logic                      typ);
    return (^data) ^ typ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Front end of the UART receiver. Synchronises the serial line
//               into the oversampling clock domain, runs the per-bit edge
//               counter, and majority-votes three samples taken around the
//               middle of every bit period.
// Ports       : clk       in   oversampling clock
//               rst_n     in   asynchronous active-low reset
//               rx_in     in   raw serial line (asynchronous to clk)
//               run       in   1 while the receiver is inside a frame
//               prescale  in   latched oversampling ratio for this frame
//               rxs       out  synchronised serial line
//               bit_val   out  majority-voted bit value (valid with bit_done)
//               bit_done  out  one-cycle strobe: a bit decision is available
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic               run,
  input  logic [PRESC_W-1:0] prescale,
  output logic               rxs,
  output logic               bit_val,
  output logic               bit_done
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRESC_W-1:0]     edge_cnt;
  logic [PRESC_W-1:0]     mid;
  logic [PRESC_W-1:0]     mid_lo;
  logic [PRESC_W-1:0]     mid_hi;
  logic [PRESC_W-1:0]     cnt_last;
  logic                   smp_lo;
  logic                   smp_mid;

  // --------------------------------------------------------------------------
  // Input synchroniser. Flops reset to 1 so the line looks idle straight out
  // of reset and no false start bit is seen.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Sample window around mid-bit.
  // --------------------------------------------------------------------------
  assign mid      = prescale >> 1;
  assign mid_lo   = mid - PRESC_ONE;
  assign mid_hi   = mid + PRESC_ONE;
  assign cnt_last = prescale - PRESC_ONE;

  // Edge counter: held at 0 while idle, so the first cycle of a frame always
  // starts at count 0 regardless of where the previous frame stopped it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else if (edge_cnt == cnt_last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESC_ONE;
    end
  end

  // The first two samples are stored; the third is the live synchronised
  // line in the decision cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_lo  <= 1'b1;
      smp_mid <= 1'b1;
    end else if (run) begin
      if (edge_cnt == mid_lo) begin
        smp_lo <= rxs;
      end
      if (edge_cnt == mid) begin
        smp_mid <= rxs;
      end
    end
  end

  assign bit_done = run && (edge_cnt == mid_hi);
  assign bit_val  = (smp_lo & smp_mid) | (smp_lo & rxs) | (smp_mid & rxs);

endmodule
`default_nettype wire

// File: rtl/uart_rx_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_gen
// Description : Parametrised UART receiver. Supports 5..9 data bits, optional
//               even/odd parity and one or two stop bits. Frame configuration
//               is latched when the start bit is detected, and a new frame
//               may begin in the cycle directly after the previous result.
// Ports       : CLK         in   oversampling clock
//               RST_n       in   asynchronous active-low reset
//               RX_IN       in   serial line, idle high, asynchronous
//               Prescale    in   oversampling ratio (even, 8..62)
//               PAR_EN      in   1 = parity bit present
//               PAR_TYP     in   0 = even parity, 1 = odd parity
//               STOP2       in   1 = two stop bits
//               P_DATA      out  last good received word (LSB first on line)
//               DATA_Valid  out  one-cycle pulse: P_DATA updated
//               PAR_ERR     out  one-cycle pulse: parity mismatch
//               FRM_ERR     out  one-cycle pulse: stop bit sampled low
//               BUSY        out  high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_W     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_Valid,
  output logic                  PAR_ERR,
  output logic                  FRM_ERR,
  output logic                  BUSY
);

  localparam int                 CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRESC_W-1:0] PRESC_MIN = PRESC_W'(MIN_PRESCALE);

  rx_state_t                 state;
  logic [PRESC_W-1:0]        presc_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      stop2_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic [CNT_W-1:0]          bit_cnt;
  logic                      par_bad;
  logic                      frm_bad;

  logic                      run;
  logic                      rxs;
  logic                      bit_val;
  logic                      bit_done;
  logic [MAX_DATA_WIDTH-1:0] shift_ext;
  logic                      par_exp;
  logic                      frm_now;
  logic                      last_stop;

  assign run = (state != ST_IDLE);

  uart_rx_sampler #(
    .PRESC_W     (PRESC_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (RST_n),
    .rx_in    (RX_IN),
    .run      (run),
    .prescale (presc_q),
    .rxs      (rxs),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  assign shift_ext = MAX_DATA_WIDTH'(shift_q);
  assign par_exp   = parity_of(shift_ext, par_typ_q);

  // Framing status including the stop decision being made this cycle, so the
  // result can be issued on the last stop decision without an extra cycle.
  assign frm_now   = frm_bad | ~bit_val;
  assign last_stop = (bit_cnt == CNT_W'(stop2_q));

  // --------------------------------------------------------------------------
  // Receive FSM, shift register, configuration latch and result registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= ST_IDLE;
      presc_q    <= PRESC_MIN;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      P_DATA     <= '0;
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      FRM_ERR    <= 1'b0;
    end else begin
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      FRM_ERR    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state     <= ST_START;
            // Ratios below the supported minimum are clamped so the sample
            // window arithmetic can never wrap.
            presc_q   <= (Prescale < PRESC_MIN) ? PRESC_MIN : Prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
            bit_cnt   <= '0;
            par_bad   <= 1'b0;
            frm_bad   <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_done) begin
            // A start bit that votes high was a glitch: drop it silently.
            state <= bit_val ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            if (bit_cnt == CNT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            if (bit_val != par_exp) begin
              par_bad <= 1'b1;
            end
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            if (!bit_val) begin
              frm_bad <= 1'b1;
            end
            if (last_stop) begin
              // Leave straight away, mid-stop-bit, so the next start edge
              // can be caught even with no idle time between frames.
              state <= ST_IDLE;
              if (!par_bad && !frm_now) begin
                P_DATA     <= shift_q;
                DATA_Valid <= 1'b1;
              end else begin
                PAR_ERR <= par_bad;
                FRM_ERR <= frm_now;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pure decode of the state register.
  assign BUSY = run;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_gen
// Description : Directed self-checking bench for uart_rx_gen. Two instances:
//               an 8-bit receiver and a 5-bit receiver sharing clock, reset
//               and configuration. Each scenario builds a per-cycle line
//               waveform, plays it in, records every result pulse with its
//               cycle index, and compares against hand-computed values.
//               Cycle index n means "seen at the falling edge n", i.e. a
//               pulse registered L cycles after the first sampling edge of a
//               start bit at line index s appears at n = s + L + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_gen;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx8     = 1'b1;
  logic       rx5     = 1'b1;
  logic [5:0] presc   = 6'd16;
  logic       par_en  = 1'b0;
  logic       par_typ = 1'b0;
  logic       stop2   = 1'b0;

  logic [7:0] pdata8;
  logic       dv8, pe8, fe8, busy8;
  logic [4:0] pdata5;
  logic       dv5, pe5, fe5, busy5;

  always #5 clk = ~clk;

  uart_rx_gen #(.DATA_WIDTH(8), .PRESC_W(6), .SYNC_STAGES(2)) dut8 (
    .CLK(clk), .RST_n(rst_n), .RX_IN(rx8), .Prescale(presc),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .P_DATA(pdata8), .DATA_Valid(dv8), .PAR_ERR(pe8), .FRM_ERR(fe8),
    .BUSY(busy8)
  );

  uart_rx_gen #(.DATA_WIDTH(5), .PRESC_W(6), .SYNC_STAGES(2)) dut5 (
    .CLK(clk), .RST_n(rst_n), .RX_IN(rx5), .Prescale(presc),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .P_DATA(pdata5), .DATA_Valid(dv5), .PAR_ERR(pe5), .FRM_ERR(fe5),
    .BUSY(busy5)
  );

  int         checks   = 0;
  int         failures = 0;

  bit         line[$];
  int         ev_cyc[$];
  logic [2:0] ev_kind[$];   // {FRM_ERR, PAR_ERR, DATA_Valid}
  logic [8:0] ev_data[$];
  bit         busy_seen;
  bit         snap_busy_pre;
  logic [8:0] snap_data;
  logic [3:0] snap_flags;   // {DATA_Valid, PAR_ERR, FRM_ERR, BUSY}

  // ---------------------------------------------------------------- stimulus
  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) line.push_back(v);
  endtask

  task automatic add_frame(input logic [8:0] data, input int width, input int blen,
                           input bit has_par, input bit par_bit,
                           input int nstop, input bit stop_val);
    add_level(1'b0, blen);
    for (int i = 0; i < width; i++) add_level(data[i], blen);
    if (has_par) add_level(par_bit, blen);
    for (int i = 0; i < nstop; i++) add_level(stop_val, blen);
  endtask

  // Plays the queued waveform into one receiver and records result pulses.
  task automatic run_line(input bit sel5, input int rst_at, input int presc_at,
                          input logic [5:0] presc_new);
    logic       v, p, f;
    logic [8:0] d;
    ev_cyc.delete();
    ev_kind.delete();
    ev_data.delete();
    busy_seen = 1'b0;
    for (int n = 0; n < line.size(); n++) begin
      @(negedge clk);
      v = sel5 ? dv5 : dv8;
      p = sel5 ? pe5 : pe8;
      f = sel5 ? fe5 : fe8;
      d = sel5 ? {4'b0, pdata5} : {1'b0, pdata8};
      if (v || p || f) begin
        ev_cyc.push_back(n);
        ev_kind.push_back({f, p, v});
        ev_data.push_back(d);
      end
      if (sel5 ? busy5 : busy8) busy_seen = 1'b1;
      if (rst_at >= 0 && n == rst_at) begin
        snap_busy_pre = busy8;
        rst_n = 1'b0;
        #1;
        snap_data  = {1'b0, pdata8};
        snap_flags = {dv8, pe8, fe8, busy8};
      end
      if (rst_at >= 0 && n == rst_at + 2) rst_n = 1'b1;
      if (presc_at >= 0 && n == presc_at) presc = presc_new;
      if (sel5) rx5 = line[n];
      else      rx8 = line[n];
    end
    line.delete();
    rx8 = 1'b1;
    rx5 = 1'b1;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pdata8 !== 8'h00) begin
      failures++; $display("FAIL reset_pdata8: got %h expected 00", pdata8);
    end
    checks++;
    if ({dv8, pe8, fe8, busy8} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags8: got %b expected 0000", {dv8, pe8, fe8, busy8});
    end
    checks++;
    if ({pdata5, dv5, pe5, fe5, busy5} !== 9'h000) begin
      failures++; $display("FAIL reset_dut5: got %h expected 000", {pdata5, dv5, pe5, fe5, busy5});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy8);
    end
  endtask

  // 8N1, Prescale 16: K = 9, latency 2 + 144 + 8 + 2 = 156.
  task automatic test_8n1_latency();
    presc = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    add_frame(9'h03A, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    add_level(1'b1, 32);
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL n81_count: got %0d events expected 1", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd157, 3'b001, 9'h03A}) begin
        failures++; $display("FAIL n81_result: got cyc=%0d kind=%b data=%h expected cyc=157 kind=001 data=03a",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
  endtask

  // 8E1, Prescale 16, 0xA5 has even weight so parity bit 0: K = 10 -> 172.
  task automatic test_parity_even();
    presc = 6'd16; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    add_frame(9'h0A5, 8, 16, 1'b1, 1'b0, 1, 1'b1);
    add_level(1'b1, 32);
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL e81_count: got %0d events expected 1", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd173, 3'b001, 9'h0A5}) begin
        failures++; $display("FAIL e81_result: got cyc=%0d kind=%b data=%h expected cyc=173 kind=001 data=0a5",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
  endtask

  // 8O2, Prescale 8: K = 11, latency 2 + 88 + 4 + 2 = 96. 0x3C needs parity 1
  // but is sent with 0; 0x55 follows 8 idle cycles later with its correct 1.
  task automatic test_parity_error();
    presc = 6'd8; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
    add_frame(9'h03C, 8, 8, 1'b1, 1'b0, 2, 1'b1);
    add_level(1'b1, 8);
    add_frame(9'h055, 8, 8, 1'b1, 1'b1, 2, 1'b1);
    add_level(1'b1, 16);
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 2) begin
      failures++; $display("FAIL o82_count: got %0d events expected 2", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd97, 3'b010, 9'h0A5}) begin
        failures++; $display("FAIL o82_parerr: got cyc=%0d kind=%b data=%h expected cyc=97 kind=010 data=0a5",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
    if (ev_cyc.size() > 1) begin
      checks++;
      if ({ev_cyc[1], ev_kind[1], ev_data[1]} !== {32'd201, 3'b001, 9'h055}) begin
        failures++; $display("FAIL o82_recover: got cyc=%0d kind=%b data=%h expected cyc=201 kind=001 data=055",
                             ev_cyc[1], ev_kind[1], ev_data[1]);
      end
    end
  endtask

  // 8N1, Prescale 32, stop bit low: K = 9, latency 2 + 288 + 16 + 2 = 308.
  // The line is still low right after the result, so a new start is opened
  // and then rejected as a glitch once the line has gone high.
  task automatic test_framing();
    presc = 6'd32; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    add_frame(9'h081, 8, 32, 1'b0, 1'b0, 1, 1'b0);
    add_level(1'b1, 96);
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL frm_count: got %0d events expected 1", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd309, 3'b100, 9'h055}) begin
        failures++; $display("FAIL frm_result: got cyc=%0d kind=%b data=%h expected cyc=309 kind=100 data=055",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
    checks++;
    if (busy8 !== 1'b0) begin
      failures++; $display("FAIL frm_busy_end: got %b expected 0", busy8);
    end
  endtask

  task automatic test_glitch();
    presc = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    add_level(1'b0, 4);
    add_level(1'b1, 60);
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (busy_seen !== 1'b1) begin
      failures++; $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen);
    end
    checks++;
    if (ev_cyc.size() !== 0) begin
      failures++; $display("FAIL glitch_no_pulse: got %0d events expected 0", ev_cyc.size());
    end
    checks++;
    if (busy8 !== 1'b0) begin
      failures++; $display("FAIL glitch_busy_end: got %b expected 0", busy8);
    end
    // One-cycle low spike on the middle sample of data bit 2 (line index
    // 3*16 + 9): the other two samples outvote it.
    add_frame(9'h0FF, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    add_level(1'b1, 32);
    line[57] = 1'b0;
    run_line(1'b0, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL spike_count: got %0d events expected 1", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd157, 3'b001, 9'h0FF}) begin
        failures++; $display("FAIL spike_result: got cyc=%0d kind=%b data=%h expected cyc=157 kind=001 data=0ff",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
  endtask

  // Partial frame aborted by reset in bit 4, then 0xC3 starting at index 128
  // with Prescale switched to 8 half-way through it.
  task automatic test_reset_midframe();
    presc = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    add_level(1'b0, 16);
    add_level(1'b0, 16);
    add_level(1'b1, 16);
    add_level(1'b0, 16);
    add_level(1'b1, 16);
    add_level(1'b1, 48);
    add_frame(9'h0C3, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    add_level(1'b1, 32);
    run_line(1'b0, 67, 176, 6'd8);
    presc = 6'd16;
    checks++;
    if (snap_busy_pre !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy_before: got %b expected 1", snap_busy_pre);
    end
    checks++;
    if ({snap_data, snap_flags} !== 13'h0000) begin
      failures++; $display("FAIL rstmid_outputs: got data=%h flags=%b expected data=000 flags=0000",
                           snap_data, snap_flags);
    end
    checks++;
    if (ev_cyc.size() !== 1) begin
      failures++; $display("FAIL rstmid_count: got %0d events expected 1", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd285, 3'b001, 9'h0C3}) begin
        failures++; $display("FAIL rstmid_result: got cyc=%0d kind=%b data=%h expected cyc=285 kind=001 data=0c3",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
  endtask

  // 5N1, Prescale 16: K = 6, latency 2 + 96 + 8 + 2 = 108; frames 112 apart.
  task automatic test_back_to_back();
    presc = 6'd16; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    add_frame(9'h01F, 5, 16, 1'b0, 1'b0, 1, 1'b1);
    add_frame(9'h00A, 5, 16, 1'b0, 1'b0, 1, 1'b1);
    add_level(1'b1, 32);
    run_line(1'b1, -1, -1, 6'd0);
    checks++;
    if (ev_cyc.size() !== 2) begin
      failures++; $display("FAIL b2b_count: got %0d events expected 2", ev_cyc.size());
    end
    if (ev_cyc.size() > 0) begin
      checks++;
      if ({ev_cyc[0], ev_kind[0], ev_data[0]} !== {32'd109, 3'b001, 9'h01F}) begin
        failures++; $display("FAIL b2b_first: got cyc=%0d kind=%b data=%h expected cyc=109 kind=001 data=01f",
                             ev_cyc[0], ev_kind[0], ev_data[0]);
      end
    end
    if (ev_cyc.size() > 1) begin
      checks++;
      if ({ev_cyc[1], ev_kind[1], ev_data[1]} !== {32'd221, 3'b001, 9'h00A}) begin
        failures++; $display("FAIL b2b_second: got cyc=%0d kind=%b data=%h expected cyc=221 kind=001 data=00a",
                             ev_cyc[1], ev_kind[1], ev_data[1]);
      end
      checks++;
      if (ev_cyc[1] - ev_cyc[0] !== 112) begin
        failures++; $display("FAIL b2b_spacing: got %0d expected 112", ev_cyc[1] - ev_cyc[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_latency();
    test_parity_even();
    test_parity_error();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
